// File: rtl/aes_in_packer.sv
// ---------------------------------------------------------------------------
// aes_in_packer
//
// Purpose:
//   Collects IN_W-bit text/key word pairs from a valid/ready stream and
//   assembles them into 128-bit text and key blocks for the AES core. A
//   complete block waits until the core is idle (or is finishing in the same
//   cycle). It is then handed over with a one-cycle ld_o strobe. The next
//   block is filled while the core works on the current one.
//
// Parameters:
//   IN_W  input word width: 8, 16, 32, 64 or 128 (must divide 128)
//
// Ports:
//   clk       clock
//   rst       synchronous, active-low reset
//   in_valid  text_in/key_in carry a valid word
//   in_ready  packer accepts a word this cycle
//   text_in   plaintext word
//   key_in    key word
//   done_i    core finished its current block (single-cycle pulse)
//   text_o    128-bit text block to the core
//   key_o     128-bit key block to the core
//   ld_o      one-cycle load strobe to the core
//   busy_o    core owns a block (load issued, done not yet seen)
//
// Configuration macro:
//   AES_IN_BYTESWAP_EN  when defined, each accepted word of text_in and key_in
//                       is byte-reversed before storage (big-endian hosts).
// ---------------------------------------------------------------------------
module aes_in_packer #(
    parameter int IN_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   text_in,
    input  logic [IN_W-1:0]   key_in,
    input  logic              done_i,
    output logic [127:0]      text_o,
    output logic [127:0]      key_o,
    output logic              ld_o,
    output logic              busy_o
);

    localparam int NW = 128 / IN_W;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    logic [CW-1:0]   cnt;
    logic            full;
    logic            core_idle;
    logic [127:0]    text_asm;
    logic [127:0]    key_asm;
    logic [IN_W-1:0] text_w;
    logic [IN_W-1:0] key_w;
    logic            accept;
    logic            last_word;
    logic            issue;

    assign in_ready  = rst & ~full;
    assign accept    = in_valid & in_ready;
    assign last_word = (cnt == CW'(NW - 1));
    // A finishing core can take the pending block in the same cycle it
    // reports done, so loading never leaves an idle gap.
    assign issue     = full & (core_idle | done_i);
    assign busy_o    = ~core_idle;

`ifdef AES_IN_BYTESWAP_EN
    // Byte 0 of the incoming word becomes the top byte of the stored word.
    function automatic logic [IN_W-1:0] byte_rev(input logic [IN_W-1:0] w);
        logic [IN_W-1:0] r;
        r = '0;
        for (int b = 0; b < IN_W / 8; b++) begin
            r[b*8 +: 8] = w[(IN_W/8 - 1 - b)*8 +: 8];
        end
        return r;
    endfunction

    assign text_w = byte_rev(text_in);
    assign key_w  = byte_rev(key_in);
`else
    assign text_w = text_in;
    assign key_w  = key_in;
`endif

    // Assembly registers are deliberately not reset: a stale partial block is
    // harmless because cnt restarts at word 0 and every word is rewritten
    // before full can be set again.
    generate
        if (NW == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (accept) begin
                    text_asm <= text_w;
                    key_asm  <= key_w;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (accept) begin
                    text_asm[int'(cnt)*IN_W +: IN_W] <= text_w;
                    key_asm[int'(cnt)*IN_W +: IN_W]  <= key_w;
                end
            end
        end
    endgenerate

    // Word counter, block-pending flag and hand-over to the core. Accept and
    // issue are mutually exclusive (accept needs ~full, issue needs full), so
    // their updates of full never collide.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            full      <= 1'b0;
            core_idle <= 1'b1;
            text_o    <= '0;
            key_o     <= '0;
            ld_o      <= 1'b0;
        end else begin
            if (accept) begin
                if (last_word) begin
                    cnt  <= '0;
                    full <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end

            if (issue) begin
                text_o    <= text_asm;
                key_o     <= key_asm;
                ld_o      <= 1'b1;
                full      <= 1'b0;
                core_idle <= 1'b0;
            end else begin
                ld_o <= 1'b0;
                if (done_i) begin
                    core_idle <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_in_packer.sv
// ---------------------------------------------------------------------------
// tb_aes_in_packer
//
// Self-checking bench for aes_in_packer. One instance uses IN_W=32 for the
// directed and randomized scenarios, a second uses IN_W=8 for the narrow-word
// and reset-mid-fill scenario. Expected blocks are built from the words the
// bench sends, with word 0 in the least significant position.
// ---------------------------------------------------------------------------
module tb_aes_in_packer;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   text_in;
    logic [31:0]   key_in;
    logic          done_i;
    logic [127:0]  text_o;
    logic [127:0]  key_o;
    logic          ld_o;
    logic          busy_o;

    logic          in_valid8;
    logic          in_ready8;
    logic [7:0]    text_in8;
    logic [7:0]    key_in8;
    logic          done_i8;
    logic [127:0]  text_o8;
    logic [127:0]  key_o8;
    logic          ld_o8;
    logic          busy_o8;

    int passed = 0;
    int total  = 0;

    aes_in_packer #(.IN_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .text_in  (text_in),
        .key_in   (key_in),
        .done_i   (done_i),
        .text_o   (text_o),
        .key_o    (key_o),
        .ld_o     (ld_o),
        .busy_o   (busy_o)
    );

    aes_in_packer #(.IN_W(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid8),
        .in_ready (in_ready8),
        .text_in  (text_in8),
        .key_in   (key_in8),
        .done_i   (done_i8),
        .text_o   (text_o8),
        .key_o    (key_o8),
        .ld_o     (ld_o8),
        .busy_o   (busy_o8)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // How a 32-bit host word ends up inside the block.
    function automatic logic [31:0] stored32(input logic [31:0] w);
`ifdef AES_IN_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [127:0] pack4(input logic [31:0] w0, input logic [31:0] w1,
                                           input logic [31:0] w2, input logic [31:0] w3);
        return {stored32(w3), stored32(w2), stored32(w1), stored32(w0)};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        total++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); else passed++;
        total++; if (ld_o !== 1'b0) $display("[TB] FAIL reset_ld: got %b expected 0", ld_o); else passed++;
        total++; if (busy_o !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); else passed++;
        total++; if (text_o !== 128'h0) $display("[TB] FAIL reset_text: got %h expected 0", text_o); else passed++;
        total++; if (key_o !== 128'h0) $display("[TB] FAIL reset_key: got %h expected 0", key_o); else passed++;
        total++; if (in_ready8 !== 1'b0) $display("[TB] FAIL reset_in_ready8: got %b expected 0", in_ready8); else passed++;
        rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready); else passed++;
        total++; if (in_ready8 !== 1'b1) $display("[TB] FAIL release_in_ready8: got %b expected 1", in_ready8); else passed++;
    endtask

    task automatic test_basic();
        logic [127:0] exp_t;
        logic [127:0] exp_k;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            text_in  = 32'(k + 1);
            key_in   = 32'h1000_0000 + 32'(k);
            step();
            if (k == 0) begin
                total++; if (in_ready !== 1'b1) $display("[TB] FAIL basic_ready_mid: got %b expected 1", in_ready); else passed++;
            end
        end
        in_valid = 1'b0;
        exp_t = pack4(32'd1, 32'd2, 32'd3, 32'd4);
        exp_k = pack4(32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003);
        total++; if (in_ready !== 1'b0) $display("[TB] FAIL basic_full_ready: got %b expected 0", in_ready); else passed++;
        total++; if (ld_o !== 1'b0) $display("[TB] FAIL basic_ld_early: got %b expected 0", ld_o); else passed++;
        step();
        total++; if (ld_o !== 1'b1) $display("[TB] FAIL basic_ld: got %b expected 1", ld_o); else passed++;
        total++; if (text_o !== exp_t) $display("[TB] FAIL basic_text: got %h expected %h", text_o, exp_t); else passed++;
        total++; if (key_o !== exp_k) $display("[TB] FAIL basic_key: got %h expected %h", key_o, exp_k); else passed++;
        total++; if (busy_o !== 1'b1) $display("[TB] FAIL basic_busy: got %b expected 1", busy_o); else passed++;
        total++; if (in_ready !== 1'b1) $display("[TB] FAIL basic_ready_after: got %b expected 1", in_ready); else passed++;
        step();
        total++; if (ld_o !== 1'b0) $display("[TB] FAIL basic_ld_pulse: got %b expected 0", ld_o); else passed++;
        total++; if (text_o !== exp_t) $display("[TB] FAIL basic_text_stable: got %h expected %h", text_o, exp_t); else passed++;
    endtask

    task automatic test_overlap();
        logic [127:0] exp_t;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            text_in  = 32'(k + 5);
            key_in   = 32'h2000_0000 + 32'(k);
            step();
        end
        text_in = 32'hDEAD_BEEF;
        key_in  = 32'hDEAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            step();
            total++; if (in_ready !== 1'b0) $display("[TB] FAIL overlap_ready: got %b expected 0", in_ready); else passed++;
            total++; if (ld_o !== 1'b0) $display("[TB] FAIL overlap_no_ld: got %b expected 0", ld_o); else passed++;
            total++; if (busy_o !== 1'b1) $display("[TB] FAIL overlap_busy: got %b expected 1", busy_o); else passed++;
        end
        in_valid = 1'b0;
        done_i   = 1'b1;
        step();
        done_i = 1'b0;
        exp_t = pack4(32'd5, 32'd6, 32'd7, 32'd8);
        total++; if (ld_o !== 1'b1) $display("[TB] FAIL overlap_ld: got %b expected 1", ld_o); else passed++;
        total++; if (text_o !== exp_t) $display("[TB] FAIL overlap_text: got %h expected %h", text_o, exp_t); else passed++;
        total++; if (busy_o !== 1'b1) $display("[TB] FAIL overlap_busy_after: got %b expected 1", busy_o); else passed++;
        total++; if (in_ready !== 1'b1) $display("[TB] FAIL overlap_ready_after: got %b expected 1", in_ready); else passed++;
        step();
        total++; if (ld_o !== 1'b0) $display("[TB] FAIL overlap_ld_pulse: got %b expected 0", ld_o); else passed++;
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        total++; if (busy_o !== 1'b0) $display("[TB] FAIL overlap_idle: got %b expected 0", busy_o); else passed++;
    endtask

    task automatic test_idle_done();
        logic [127:0] exp_t;
        exp_t = pack4(32'd5, 32'd6, 32'd7, 32'd8);
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        total++; if (ld_o !== 1'b0) $display("[TB] FAIL idle_done_ld: got %b expected 0", ld_o); else passed++;
        total++; if (busy_o !== 1'b0) $display("[TB] FAIL idle_done_busy: got %b expected 0", busy_o); else passed++;
        step();
        total++; if (ld_o !== 1'b0) $display("[TB] FAIL idle_done_ld2: got %b expected 0", ld_o); else passed++;
        total++; if (text_o !== exp_t) $display("[TB] FAIL idle_done_text: got %h expected %h", text_o, exp_t); else passed++;
    endtask

    task automatic test_byteswap();
        logic [127:0] exp_t;
        logic [127:0] exp_k;
`ifdef AES_IN_BYTESWAP_EN
        exp_t = 128'h44332211_44332211_44332211_44332211;
        exp_k = 128'h88776655_88776655_88776655_88776655;
`else
        exp_t = 128'h11223344_11223344_11223344_11223344;
        exp_k = 128'h55667788_55667788_55667788_55667788;
`endif
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            text_in  = 32'h1122_3344;
            key_in   = 32'h5566_7788;
            step();
        end
        in_valid = 1'b0;
        step();
        total++; if (ld_o !== 1'b1) $display("[TB] FAIL swap_ld: got %b expected 1", ld_o); else passed++;
        total++; if (text_o !== exp_t) $display("[TB] FAIL swap_text: got %h expected %h", text_o, exp_t); else passed++;
        total++; if (key_o !== exp_k) $display("[TB] FAIL swap_key: got %h expected %h", key_o, exp_k); else passed++;
        done_i = 1'b1;
        step();
        done_i = 1'b0;
    endtask

    task automatic test_narrow();
        logic [127:0] exp_k;
        exp_k = '0;
        for (int k = 0; k < 16; k++) begin
            in_valid8 = 1'b1;
            text_in8  = 8'(k);
            key_in8   = 8'hFF - 8'(k);
            exp_k     = exp_k | (128'(8'hFF - 8'(k)) << (8 * k));
            step();
        end
        in_valid8 = 1'b0;
        step();
        total++; if (ld_o8 !== 1'b1) $display("[TB] FAIL narrow_ld: got %b expected 1", ld_o8); else passed++;
        total++; if (text_o8 !== 128'h0F0E0D0C0B0A09080706050403020100)
            $display("[TB] FAIL narrow_text: got %h expected 0f0e0d0c0b0a09080706050403020100", text_o8); else passed++;
        total++; if (key_o8 !== exp_k) $display("[TB] FAIL narrow_key: got %h expected %h", key_o8, exp_k); else passed++;
        // Core stays busy; three words of a partial block, then reset.
        for (int k = 0; k < 3; k++) begin
            in_valid8 = 1'b1;
            text_in8  = 8'h55 + 8'(k);
            key_in8   = 8'h55 + 8'(k);
            step();
        end
        in_valid8 = 1'b0;
        total++; if (busy_o8 !== 1'b1) $display("[TB] FAIL narrow_busy: got %b expected 1", busy_o8); else passed++;
        rst = 1'b0;
        step();
        rst = 1'b1;
        total++; if (busy_o8 !== 1'b0) $display("[TB] FAIL narrow_reset_busy: got %b expected 0", busy_o8); else passed++;
        total++; if (text_o8 !== 128'h0) $display("[TB] FAIL narrow_reset_text: got %h expected 0", text_o8); else passed++;
        exp_k = '0;
        for (int k = 0; k < 16; k++) begin
            in_valid8 = 1'b1;
            text_in8  = 8'hA0 + 8'(k);
            key_in8   = 8'h30 + 8'(k);
            exp_k     = exp_k | (128'(8'h30 + 8'(k)) << (8 * k));
            step();
        end
        in_valid8 = 1'b0;
        step();
        total++; if (ld_o8 !== 1'b1) $display("[TB] FAIL narrow2_ld: got %b expected 1", ld_o8); else passed++;
        total++; if (text_o8 !== 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0)
            $display("[TB] FAIL narrow2_text: got %h expected afaeadacabaaa9a8a7a6a5a4a3a2a1a0", text_o8); else passed++;
        total++; if (key_o8 !== exp_k) $display("[TB] FAIL narrow2_key: got %h expected %h", key_o8, exp_k); else passed++;
        done_i8 = 1'b1;
        step();
        done_i8 = 1'b0;
    endtask

    // Random valid/done traffic on the 32-bit instance. The reference model
    // keeps the words of the block being filled, a FIFO of completed blocks
    // waiting for the core, and whether the core currently owns a block.
    task automatic test_random();
        logic [31:0]  cur_t;
        logic [31:0]  cur_k;
        logic [127:0] acc_t;
        logic [127:0] acc_k;
        logic [255:0] pend_q[$];
        logic [255:0] exp_blk;
        int           nwords;
        int           issued;
        int           cycles;
        bit           idle;
        bit           exp_ready;
        bit           do_issue;

        cur_t  = $urandom;
        cur_k  = $urandom;
        acc_t  = '0;
        acc_k  = '0;
        nwords = 0;
        issued = 0;
        cycles = 0;
        idle   = 1'b1;
        exp_blk = '0;

        while (issued < 1000 && cycles < 40000) begin
            in_valid = ($urandom_range(0, 9) < 7);
            text_in  = cur_t;
            key_in   = cur_k;
            done_i   = idle ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) == 0);

            exp_ready = (pend_q.size() == 0);
            total++; if (in_ready !== exp_ready) $display("[TB] FAIL rand_ready: got %b expected %b", in_ready, exp_ready); else passed++;

            do_issue = (pend_q.size() != 0) && (idle || done_i);
            if (do_issue) begin
                exp_blk = pend_q.pop_front();
                idle    = 1'b0;
            end else if (done_i) begin
                idle = 1'b1;
            end

            if (in_valid && exp_ready) begin
                acc_t  = acc_t | (128'(stored32(cur_t)) << (32 * nwords));
                acc_k  = acc_k | (128'(stored32(cur_k)) << (32 * nwords));
                nwords++;
                if (nwords == 4) begin
                    pend_q.push_back({acc_t, acc_k});
                    acc_t  = '0;
                    acc_k  = '0;
                    nwords = 0;
                end
                cur_t = $urandom;
                cur_k = $urandom;
            end

            step();
            cycles++;

            total++; if (ld_o !== do_issue) $display("[TB] FAIL rand_ld: got %b expected %b at block %0d", ld_o, do_issue, issued); else passed++;
            if (do_issue) begin
                total++; if (text_o !== exp_blk[255:128]) $display("[TB] FAIL rand_text: got %h expected %h at block %0d", text_o, exp_blk[255:128], issued); else passed++;
                total++; if (key_o !== exp_blk[127:0]) $display("[TB] FAIL rand_key: got %h expected %h at block %0d", key_o, exp_blk[127:0], issued); else passed++;
                issued++;
            end
            total++; if (busy_o !== !idle) $display("[TB] FAIL rand_busy: got %b expected %b", busy_o, !idle); else passed++;
        end
        in_valid = 1'b0;
        done_i   = 1'b0;
        total++; if (issued !== 1000) $display("[TB] FAIL rand_block_count: got %0d expected 1000 within cycle budget", issued); else passed++;
    endtask

    initial begin
        in_valid  = 1'b0;
        text_in   = '0;
        key_in    = '0;
        done_i    = 1'b0;
        in_valid8 = 1'b0;
        text_in8  = '0;
        key_in8   = '0;
        done_i8   = 1'b0;

        test_reset();
        test_basic();
        test_overlap();
        test_idle_done();
        test_byteswap();
        test_narrow();
        test_random();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected to have finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
